iter_muldiv: RTL and testbench

Iterative multiply/divide unit executing all eight RV32M operations, parametrised in data width. It sits beside the single-cycle ALU in the multicycle datapath: the control FSM issues an operation with `start`, holds its own state while `busy` is high, and writes `result` to ALUOut when `done` pulses. Latency is fixed and identical for every operation and operand value, including the divide-by-zero and overflow cases.

---
 rtl/iter_muldiv.sv | 124 ++++++++++++
 tb/tb_iter_muldiv.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add or restoring division over XLEN cycles plus one fix-up cycle.
// Fixed latency XLEN+1 edges from start to done; start is ignored while busy (no queueing).
module iter_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, ma, mb;
  logic              sa, sb;
  logic [2*XLEN-1:0] p;

  // Operand signedness and magnitudes at issue time
  logic            a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0] ma_in, mb_in;
  assign a_sgn_in = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_sgn_in = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign a_neg_in = a_sgn_in & a[XLEN-1];
  assign b_neg_in = b_sgn_in & b[XLEN-1];
  assign ma_in    = a_neg_in ? -a : a;
  assign mb_in    = b_neg_in ? -b : b;

  // One iteration step. For divide, p holds {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] p_step;
  assign mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, ma} : {(XLEN+1){1'b0}});
  assign div_sh  = p[2*XLEN-1:XLEN-1];
  assign div_ge  = div_sh >= {1'b0, mb};
  assign div_sub = div_sh[XLEN-1:0] - mb;
  assign p_step  = op_q[2] ? (div_ge ? {div_sub, p[XLEN-2:0], 1'b1} : {p[2*XLEN-2:0], 1'b0})
                           : {mul_sum, p[XLEN-1:1]};

  // Sign correction and divide-by-zero override
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  assign prod  = (sa ^ sb) ? -p : p;
  assign quo_s = (sa ^ sb) ? -p[XLEN-1:0] : p[XLEN-1:0];
  assign rem_s = sa ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = (b_q == '0) ? '1 : quo_s;
      default:                fix_res = (b_q == '0) ? a_q : rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ma     <= '0;
      mb     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      p      <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
          ma   <= ma_in;
          mb   <= mb_in;
          sa   <= a_neg_in;
          sb   <= b_neg_in;
          cnt  <= '0;
          // Multiply shifts the multiplier out of the low half; divide shifts the dividend in.
          p    <= {{XLEN{1'b0}}, op[2] ? ma_in : mb_in};
        end
        CALC: begin
          p   <= p_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_muldiv.sv
// Directed-vector bench for iter_muldiv at XLEN=32 plus an 8-bit instance checked against a reference model.
module tb_iter_muldiv;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [2:0]  op, op8;
  logic [31:0] a, b, result;
  logic [7:0]  a8, b8, result8;
  logic        busy, done, busy8, done8;

  int tests = 0;
  int fails = 0;
  int overlap = 0;

  iter_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  iter_muldiv #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done)   overlap++;
    if (busy8 && done8) overlap++;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic do32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] r, output int lat, output logic was_done);
    int guard = 0;
    @(negedge clk);
    was_done = done;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    r = result;
  endtask

  task automatic do8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                     output logic [7:0] r, output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done8 && lat < 50);
    r = result8;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  function automatic logic [7:0] ref8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    longint sx, sy, pr;
    int ix, iy, q;
    logic [7:0] r;
    sx = (o == 3'd1 || o == 3'd2) ? longint'($signed(x)) : longint'({56'd0, x});
    sy = (o == 3'd1) ? longint'($signed(y)) : longint'({56'd0, y});
    pr = sx * sy;
    ix = (o == 3'd4 || o == 3'd6) ? int'($signed(x)) : int'({24'd0, x});
    iy = (o == 3'd4 || o == 3'd6) ? int'($signed(y)) : int'({24'd0, y});
    case (o)
      3'd0:       r = pr[7:0];
      3'd1, 3'd2,
      3'd3:       r = pr[15:8];
      3'd4, 3'd5: begin
        if (y == 8'd0) r = 8'hFF;
        else begin q = ix / iy; r = q[7:0]; end
      end
      default: begin
        if (y == 8'd0) r = x;
        else begin q = ix % iy; r = q[7:0]; end
      end
    endcase
    return r;
  endfunction

  logic [7:0] vals[16];

  initial begin
    logic [31:0] r;
    logic [7:0]  r8;
    int          lat, nd;
    logic        wd;

    vt[0]  = '{3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA};
    vt[1]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vt[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vt[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vt[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vt[7]  = '{3'b101, 32'd100,      32'd7,        32'd14};
    vt[8]  = '{3'b111, 32'd100,      32'd7,        32'd2};
    vt[9]  = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vt[10] = '{3'b101, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vt[11] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
    vt[12] = '{3'b111, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
    vt[13] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vt[14] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vt[15] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vt[16] = '{3'b010, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};

    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h40, 8'h55,
             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC0, 8'hF9, 8'hFE, 8'hFF};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", {32'd0, result}, 64'd0);
    chk("reset_busy8", {63'd0, busy8}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do32(vt[i].op, vt[i].a, vt[i].b, r, lat, wd);
      chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vt[i].exp});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
    end

    // Restart pulse at cycle 10 and operand churn must not disturb the in-flight DIVU.
    @(negedge clk);
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) begin
        start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
    end while (!done && lat < 100);
    start = 1'b0;
    chk("ignored_start_result", {32'd0, result}, 64'd14);
    chk("ignored_start_latency", 64'(lat), 64'd33);
    count_done(40, nd);
    chk("ignored_start_no_queue", 64'(nd), 64'd0);
    chk("ignored_start_hold", {32'd0, result}, 64'd14);

    // Back-to-back: the second start is driven in the done cycle of the first.
    do32(3'b000, 32'd6, 32'd7, r, lat, wd);
    chk("b2b_first", {32'd0, r}, 64'd42);
    do32(3'b000, 32'd3, 32'd5, r, lat, wd);
    chk("b2b_start_in_done", {63'd0, wd}, 64'd1);
    chk("b2b_second", {32'd0, r}, 64'd15);
    chk("b2b_latency", 64'(lat), 64'd33);

    // Asynchronous reset between edges at cycle 15 of a DIV.
    @(negedge clk);
    op = 3'b100; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    chk("async_reset_done", {63'd0, done}, 64'd0);
    chk("async_reset_result", {32'd0, result}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_done(40, nd);
    chk("aborted_no_done", 64'(nd), 64'd0);
    do32(3'b000, 32'd6, 32'd7, r, lat, wd);
    chk("post_reset_mul", {32'd0, r}, 64'd42);

    // 8-bit instance over boundary-heavy operand set, all eight ops.
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          do8(3'(o), vals[i], vals[j], r8, lat);
          chk($sformatf("x8_op%0d_%0h_%0h", o, vals[i], vals[j]), {56'd0, r8},
              {56'd0, ref8(3'(o), vals[i], vals[j])});
          if (lat != 9) chk($sformatf("x8_latency_op%0d", o), 64'(lat), 64'd9);
        end
      end
    end

    chk("busy_done_overlap", 64'(overlap), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
